// File: rtl/ram_fifo_ctrl.sv
// ram_fifo_ctrl: FIFO controller in front of a single-port RAM.
// Turns push/pop handshakes into single-cycle RAM strobes, keeps circular
// write/read pointers with an occupancy count, and returns popped bytes with
// a one-cycle valid pulse. Every operation passes through IDLE, so the RAM
// sees at most one access every two cycles.
module ram_fifo_ctrl #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 8
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_clr,
  input  logic              i_push_valid,
  input  logic [DATA_W-1:0] i_push_data,
  output logic              o_push_ready,
  input  logic              i_pop_valid,
  output logic              o_pop_ready,
  output logic              o_rd_valid,
  output logic [DATA_W-1:0] o_rd_data,
  output logic [ADDR_W:0]   o_count,
  output logic              o_full,
  output logic              o_empty,
  output logic              o_ram_wr,
  output logic              o_ram_rd,
  output logic [ADDR_W-1:0] o_ram_addr,
  output logic [DATA_W-1:0] o_ram_data_in,
  input  logic [DATA_W-1:0] i_ram_data_out
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WR   = 2'd1,
    S_RD   = 2'd2
  } state_t;

  // Occupancy value meaning "every RAM entry holds unread data".
  localparam logic [ADDR_W:0] FULL_CNT = {1'b1, {ADDR_W{1'b0}}};

  state_t              r_state;
  state_t              w_state_next;
  logic [ADDR_W-1:0]   r_wptr;
  logic [ADDR_W-1:0]   r_rptr;
  logic [ADDR_W:0]     r_count;
  logic                r_last_wr;      // last accepted op was a push
  logic                r_ram_wr;
  logic                r_ram_rd;
  logic [ADDR_W-1:0]   r_ram_addr;
  logic [DATA_W-1:0]   r_ram_data_in;
  logic                r_rd_valid;
  logic [DATA_W-1:0]   r_rd_data;

  logic                w_full;
  logic                w_empty;
  logic                w_idle;
  logic                w_can_push;
  logic                w_can_pop;
  logic                w_tie;
  logic                w_push_ready;
  logic                w_pop_ready;
  logic                w_push_fire;
  logic                w_pop_fire;

  assign w_full  = (r_count == FULL_CNT);
  assign w_empty = (r_count == '0);

  // State register; reset parks the controller in IDLE.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Handshake arbitration and next-state: WR/RD always fall back to IDLE.
  always_comb begin
    w_state_next = r_state;
    w_idle       = (r_state == S_IDLE);
    w_can_push   = w_idle & ~w_full  & ~i_clr;
    w_can_pop    = w_idle & ~w_empty & ~i_clr;
    // On a tie the side that did not go last wins; the loser sees ready=0.
    w_tie        = i_push_valid & i_pop_valid & w_can_push & w_can_pop;
    w_push_ready = w_can_push & ~(w_tie &  r_last_wr);
    w_pop_ready  = w_can_pop  & ~(w_tie & ~r_last_wr);
    w_push_fire  = i_push_valid & w_push_ready;
    w_pop_fire   = i_pop_valid  & w_pop_ready;
    case (r_state)
      S_IDLE: begin
        if (w_push_fire) begin
          w_state_next = S_WR;
        end else if (w_pop_fire) begin
          w_state_next = S_RD;
        end
      end
      S_WR:    w_state_next = S_IDLE;
      S_RD:    w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
    if (i_clr) begin
      w_state_next = S_IDLE;
    end
  end

  // RAM strobes are registered at accept time so address/data are stable for the whole strobe cycle.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_ram_wr      <= 1'b0;
      r_ram_rd      <= 1'b0;
      r_ram_addr    <= '0;
      r_ram_data_in <= '0;
      r_last_wr     <= 1'b0;
    end else begin
      r_ram_wr <= w_push_fire;
      r_ram_rd <= w_pop_fire;
      if (w_push_fire) begin
        r_ram_addr    <= r_wptr;
        r_ram_data_in <= i_push_data;
      end else if (w_pop_fire) begin
        r_ram_addr    <= r_rptr;
      end
      if (w_push_fire | w_pop_fire) begin
        r_last_wr <= w_push_fire;
      end
    end
  end

  // Pointer/count bookkeeping happens as the strobe cycle ends; a flush discards the in-flight op.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_count    <= '0;
      r_rd_valid <= 1'b0;
      r_rd_data  <= '0;
    end else begin
      r_rd_valid <= 1'b0;
      if (i_clr) begin
        r_wptr  <= '0;
        r_rptr  <= '0;
        r_count <= '0;
      end else if (r_state == S_WR) begin
        r_wptr  <= r_wptr + 1'b1;
        r_count <= r_count + 1'b1;
      end else if (r_state == S_RD) begin
        r_rptr     <= r_rptr + 1'b1;
        r_count    <= r_count - 1'b1;
        r_rd_data  <= i_ram_data_out;
        r_rd_valid <= 1'b1;
      end
    end
  end

  assign o_push_ready  = w_push_ready;
  assign o_pop_ready   = w_pop_ready;
  assign o_rd_valid    = r_rd_valid;
  assign o_rd_data     = r_rd_data;
  assign o_count       = r_count;
  assign o_full        = w_full;
  assign o_empty       = w_empty;
  assign o_ram_wr      = r_ram_wr;
  assign o_ram_rd      = r_ram_rd;
  assign o_ram_addr    = r_ram_addr;
  assign o_ram_data_in = r_ram_data_in;

endmodule

// File: tb/tb_ram_fifo_ctrl.sv
// Bench for ram_fifo_ctrl: a 1Kx8 RAM model, a queue-based FIFO reference
// checked against the DUT every cycle, directed scenarios with literal
// expectations, then a randomized push/pop/flush phase.
module tb_ram_fifo_ctrl;
  localparam int DEPTH = 1024;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       clr = 1'b0;
  logic       push_valid = 1'b0;
  logic [7:0] push_data = 8'h00;
  logic       push_ready;
  logic       pop_valid = 1'b0;
  logic       pop_ready;
  logic       rd_valid;
  logic [7:0] rd_data;
  logic [10:0] count;
  logic       full, empty, ram_wr, ram_rd;
  logic [9:0] ram_addr;
  logic [7:0] ram_data_in, ram_data_out;

  int errors = 0;
  int checks = 0;

  ram_fifo_ctrl #(.ADDR_W(10), .DATA_W(8)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_clr(clr),
    .i_push_valid(push_valid), .i_push_data(push_data), .o_push_ready(push_ready),
    .i_pop_valid(pop_valid), .o_pop_ready(pop_ready),
    .o_rd_valid(rd_valid), .o_rd_data(rd_data), .o_count(count),
    .o_full(full), .o_empty(empty), .o_ram_wr(ram_wr), .o_ram_rd(ram_rd),
    .o_ram_addr(ram_addr), .o_ram_data_in(ram_data_in), .i_ram_data_out(ram_data_out)
  );

  always #5 clk = ~clk;

  // Single-port RAM: synchronous write, combinational read while Rd is high.
  logic [7:0] mem [DEPTH];
  always @(posedge clk) if (ram_wr) mem[ram_addr] <= ram_data_in;
  assign ram_data_out = ram_rd ? mem[ram_addr] : 8'h00;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      if (errors <= 40) $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // Contents are a byte queue; phase says which single-cycle op is in flight.
  byte unsigned m_q[$];
  int  m_phase = 0;          // 0 none, 1 write strobe cycle, 2 read strobe cycle
  int  m_wptr = 0, m_rptr = 0;
  int  m_addr = 0;
  int  m_din = 0;
  int  m_rd = 0;
  bit  m_rdv = 0;
  bit  m_last_wr = 0;

  function automatic void m_ready(input bit pv, input bit qv, input bit cl, output bit pr, output bit qr);
    bit bp, bq, tie;
    bp  = (m_phase == 0) && (m_q.size() < DEPTH) && !cl;
    bq  = (m_phase == 0) && (m_q.size() > 0) && !cl;
    tie = pv && qv && bp && bq;
    pr  = bp && !(tie && m_last_wr);
    qr  = bq && !(tie && !m_last_wr);
  endfunction

  initial begin
    bit pr, qr, nrdv;
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        m_q.delete(); m_phase = 0; m_wptr = 0; m_rptr = 0; m_addr = 0;
        m_din = 0; m_rd = 0; m_rdv = 0; m_last_wr = 0;
      end else begin
        m_ready(push_valid, pop_valid, clr, pr, qr);
        nrdv = 0;
        if (clr) begin
          m_q.delete(); m_wptr = 0; m_rptr = 0;
        end else if (m_phase == 1) begin
          m_q.push_back(byte'(m_din)); m_wptr = (m_wptr + 1) % DEPTH;
        end else if (m_phase == 2 && m_q.size() > 0) begin
          m_rd = m_q.pop_front(); m_rptr = (m_rptr + 1) % DEPTH; nrdv = 1;
        end
        m_phase = 0;
        if (push_valid && pr) begin
          m_phase = 1; m_addr = m_wptr; m_din = push_data; m_last_wr = 1;
        end else if (pop_valid && qr) begin
          m_phase = 2; m_addr = m_rptr; m_last_wr = 0;
        end
        m_rdv = nrdv;
      end
    end
  end

  // Every-cycle comparison against the model, on the falling edge.
  initial begin
    bit epr, eqr;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        m_ready(push_valid, pop_valid, clr, epr, eqr);
        check("push_ready", push_ready, epr);
        check("pop_ready", pop_ready, eqr);
        check("count", count, m_q.size());
        check("full", full, m_q.size() == DEPTH);
        check("empty", empty, m_q.size() == 0);
        check("ram_wr", ram_wr, m_phase == 1);
        check("ram_rd", ram_rd, m_phase == 2);
        check("ram_addr", ram_addr, m_addr);
        check("ram_data_in", ram_data_in, m_din);
        check("rd_valid", rd_valid, m_rdv);
        check("rd_data", rd_data, m_rd);
      end
    end
  end

  // Event logs used by the literal checks.
  int wr_addr_q[$], wr_data_q[$], rd_addr_q[$], rdv_q[$];
  initial forever begin
    @(negedge clk);
    if (rst_n) begin
      if (ram_wr) begin wr_addr_q.push_back(ram_addr); wr_data_q.push_back(ram_data_in); end
      if (ram_rd) rd_addr_q.push_back(ram_addr);
      if (rd_valid) rdv_q.push_back(rd_data);
    end
  end

  // Cycle watchdog.
  initial begin
    int cyc = 0;
    forever begin
      @(posedge clk);
      cyc++;
      if (cyc > 90000) begin
        $display("FAIL watchdog: cycles=%0d limit=90000", cyc);
        $fatal(1, "watchdog expired");
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic step(input bit pv, input logic [7:0] pd, input bit qv, input bit cl,
                      output bit pacc, output bit qacc);
    push_valid = pv; push_data = pd; pop_valid = qv; clr = cl;
    @(negedge clk);
    pacc = pv && push_ready;
    qacc = qv && pop_ready;
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    bit pa, qa;
    for (int i = 0; i < n; i++) step(0, 8'h00, 0, 0, pa, qa);
  endtask

  task automatic push_b(input logic [7:0] d);
    bit pa, qa;
    int n = 0;
    do begin step(1, d, 0, 0, pa, qa); n++; end while (!pa && n < 20);
    if (!pa) check("push_timeout", 0, 1);
  endtask

  task automatic pop_b();
    bit pa, qa;
    int n = 0;
    do begin step(0, 8'h00, 1, 0, pa, qa); n++; end while (!qa && n < 20);
    if (!qa) check("pop_timeout", 0, 1);
  endtask

  // ---------------- directed + random scenarios ----------------
  initial begin
    bit pa, qa;
    int ops[$];
    int nrdv, nwr;

    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    check("rst_count", count, 0);
    check("rst_empty", empty, 1);
    check("rst_ram_wr", ram_wr, 0);
    check("rst_ram_addr", ram_addr, 0);
    check("rst_rd_valid", rd_valid, 0);
    check("rst_rd_data", rd_data, 0);

    // 1: four pushes of 0x07
    wr_addr_q.delete(); wr_data_q.delete();
    for (int i = 0; i < 4; i++) push_b(8'h07);
    idle(1);
    check("t1_nwr", wr_addr_q.size(), 4);
    for (int i = 0; i < 4 && i < wr_addr_q.size(); i++) begin
      check("t1_addr", wr_addr_q[i], i);
      check("t1_data", wr_data_q[i], 8'h07);
    end
    check("t1_count", count, 4);
    check("t1_empty", empty, 0);

    // 2: four pops
    rd_addr_q.delete(); rdv_q.delete();
    for (int i = 0; i < 4; i++) pop_b();
    idle(2);
    check("t2_nrd", rd_addr_q.size(), 4);
    for (int i = 0; i < 4 && i < rd_addr_q.size(); i++) check("t2_addr", rd_addr_q[i], i);
    check("t2_nrdv", rdv_q.size(), 4);
    for (int i = 0; i < rdv_q.size(); i++) check("t2_data", rdv_q[i], 8'h07);
    check("t2_count", count, 0);
    check("t2_empty", empty, 1);

    // 3: fill completely, overflow attempt, drain
    step(0, 8'h00, 0, 1, pa, qa);
    for (int i = 0; i < DEPTH; i++) push_b(8'(i));
    idle(1);
    check("t3_full", full, 1);
    check("t3_count", count, 1024);
    nwr = wr_addr_q.size();
    for (int i = 0; i < 4; i++) step(1, 8'hEE, 0, 0, pa, qa);
    check("t3_push_ready", push_ready, 0);
    check("t3_extra_wr", wr_addr_q.size(), nwr);
    push_valid = 1'b0;
    rdv_q.delete();
    for (int i = 0; i < DEPTH; i++) pop_b();
    idle(2);
    check("t3_nrdv", rdv_q.size(), DEPTH);
    for (int i = 0; i < rdv_q.size(); i++) check("t3_data", rdv_q[i], i % 256);

    // 4: wrap-around
    step(0, 8'h00, 0, 1, pa, qa);
    for (int i = 0; i < DEPTH; i++) push_b(8'(i));
    idle(1);
    rdv_q.delete();
    pop_b(); pop_b();
    wr_addr_q.delete(); wr_data_q.delete();
    push_b(8'hAA); push_b(8'hBB);
    idle(1);
    check("t4_nwr", wr_addr_q.size(), 2);
    if (wr_addr_q.size() == 2) begin
      check("t4_addr0", wr_addr_q[0], 0);
      check("t4_addr1", wr_addr_q[1], 1);
    end
    for (int i = 0; i < DEPTH; i++) pop_b();
    idle(2);
    check("t4_nrdv", rdv_q.size(), DEPTH + 2);
    for (int i = 0; i < rdv_q.size(); i++)
      check("t4_data", rdv_q[i], (i < DEPTH) ? (i % 256) : ((i == DEPTH) ? 8'hAA : 8'hBB));

    // 5: both valid held with count=5 and a read as the last op
    step(0, 8'h00, 0, 1, pa, qa);
    for (int i = 0; i < 6; i++) push_b(8'(8'h30 + i));
    pop_b();
    idle(2);
    check("t5_start_count", count, 5);
    ops.delete();
    for (int i = 0; i < 8; i++) begin
      step(1, 8'h5A, 1, 0, pa, qa);
      if (pa) ops.push_back(1);
      if (qa) ops.push_back(2);
      check("t5_count_range", (count >= 5 && count <= 6), 1);
    end
    push_valid = 1'b0; pop_valid = 1'b0;
    check("t5_nops", ops.size(), 4);
    for (int i = 0; i < ops.size(); i++) check("t5_op", ops[i], (i % 2 == 0) ? 1 : 2);
    idle(2);

    // 6a: reset during a write strobe
    push_b(8'h11);
    push_valid = 1'b0;
    check("t6_wr_before", ram_wr, 1);
    #2 rst_n = 1'b0;
    #1 check("t6_wr_dropped", ram_wr, 0);
    @(posedge clk); #1 rst_n = 1'b1;
    idle(2);
    check("t6_count", count, 0);
    check("t6_empty", empty, 1);

    // 6b: flush during a read strobe
    push_b(8'h21); push_b(8'h22);
    pop_b();
    check("t6_rd_before", ram_rd, 1);
    nrdv = rdv_q.size();
    step(0, 8'h00, 0, 1, pa, qa);
    idle(3);
    check("t6_no_rdv", rdv_q.size(), nrdv);
    check("t6_clr_count", count, 0);

    // Random push/pop/flush traffic against the model.
    for (int i = 0; i < 3000; i++)
      step($urandom_range(0, 3) != 0, 8'($urandom), $urandom_range(0, 2) == 0,
           $urandom_range(0, 99) == 0, pa, qa);
    idle(3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
